uop_issue_controller: RTL
=========================

Name: uop_issue_controller

Overview:
- Multi-cycle issue/sequencing controller for the microcoded RV32 core.
- Accepts one instruction at a time from fetch, together with the 6-bit microcode address produced by the opcode/funct decoder.
- Classifies the address, walks the instruction through EXEC/MEM/MUL-wait/WB phases, and drives register-write, PC-redirect, memory and multiplier handshakes.
- Flags illegal encodings and multiplier timeouts as traps.

Parameters:
- MUL_TIMEOUT, 32, max cycles spent in MULW waiting for mul_done before trapping (must be >=2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  controller can accept; high only in IDLE.
- mapped_addr  in  6  decoder microcode address; sampled on accept.
- branch_taken  in  1  branch comparator result; sampled in EXEC.
- mem_req  out  1  memory request for load/store.
- mem_ack  in  1  memory completion.
- mul_start  out  1  one-cycle multiplier start pulse.
- mul_done  in  1  multiplier result valid.
- uop_addr  out  6  latched microcode address driving datapath control.
- reg_we  out  1  register-file write enable.
- pc_redirect  out  1  next PC comes from branch/jump target.
- retire  out  1  one-cycle pulse per retired instruction.
- trap  out  1  one-cycle trap pulse.
- trap_cause  out  2  0 none, 1 illegal, 2 mul timeout; held until next accept.
- retire_count  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset (reset=0, async): state=IDLE; uop_addr, trap_cause, retire_count, timeout counter and taken latch all cleared; all strobes 0.
- Reset mid-operation: the in-flight instruction is abandoned and mem_req drops immediately.
- Address classes:
  - 0 = NOP.
  - 1-10, 14-24 = ALU.
  - 11 = LOAD; 12 = STORE; 13 = BRANCH.
  - 25, 26 = JUMP.
  - 27-29 = MUL.
  - 30-63 = ILLEGAL.
- States: IDLE, EXEC, MEM, MULW, WB, TRAP.
- IDLE:
  - instr_ready=1.
  - On instr_valid=1, latch mapped_addr into uop_addr and clear trap_cause.
  - Next state: ILLEGAL -> TRAP, MUL -> MULW, all other classes -> EXEC.
- EXEC (1 cycle):
  - BRANCH: latch branch_taken.
  - LOAD/STORE -> MEM; otherwise -> WB.
- MEM:
  - mem_req=1 in every MEM cycle.
  - Stays in MEM until mem_ack=1 is sampled, then -> WB.
  - mem_ack outside MEM is ignored.
- MULW:
  - mul_start=1 only in the first MULW cycle.
  - The timeout counter starts at 0 and increments each MULW cycle.
  - mul_done=1 -> WB.
  - If the counter reaches MUL_TIMEOUT-1 with mul_done=0: trap_cause=2, next state TRAP.
  - mul_done in the same cycle as timeout: done wins.
  - mul_done outside MULW is ignored.
- WB (1 cycle), then -> IDLE:
  - retire=1.
  - reg_we=1 for ALU, LOAD, JUMP, MUL; 0 for NOP, STORE, BRANCH.
  - pc_redirect=1 for JUMP, and for BRANCH when the latched taken=1.
  - retire_count increments by 1 and wraps to 0 at 2^CNT_W.
- TRAP (1 cycle), then -> IDLE:
  - trap=1.
  - For an illegal encoding, trap_cause=1 is set on entry.
  - No reg_we, no retire, no count increment.
- Latencies from accept edge:
  - ALU/NOP/BRANCH/JUMP: WB in 2nd cycle after accept; next accept possible 3 cycles after previous.
  - LOAD/STORE: 3 + (cycles mem_ack is late).
  - MUL: WB in the cycle after mul_done is seen.
- uop_addr is held stable from accept until the next accept.
- No back-to-back accept: instr_ready=0 outside IDLE.

Test Plan:
- Reset release, then ADD (mapped_addr=1) accepted at edge 0:
  - EXEC at cycle 1; WB at cycle 2 with reg_we=1, retire=1, pc_redirect=0.
  - retire_count=1; instr_ready=1 at cycle 3.
- LOAD (11), mem_ack held low 4 MEM cycles then high:
  - mem_req=1 for exactly 5 cycles.
  - WB next with reg_we=1.
  - STORE (12) with the same ack timing -> same mem_req duration, WB with reg_we=0.
- BRANCH (13) with branch_taken=1 in EXEC -> WB pc_redirect=1, reg_we=0.
  - Repeat with branch_taken=0 -> pc_redirect=0.
  - JALR (26) -> reg_we=1, pc_redirect=1.
- MUL (27) with MUL_TIMEOUT=8:
  - mul_done after 3 cycles -> one mul_start pulse, WB with reg_we=1.
  - mul_done never asserted -> trap=1, trap_cause=2 after 8 MULW cycles, retire_count unchanged.
- mapped_addr=63 and mapped_addr=30 -> TRAP the cycle after accept, trap_cause=1, no reg_we.
  - A following NOP (0) -> retire=1, reg_we=0, trap_cause cleared.
- Assert reset=0 mid-MEM with mem_req=1 -> mem_req=0 and state=IDLE immediately (before next clk edge), retire_count=0.
  - After release, a new ADD completes normally.

Source files
------------

// File: rtl/uop_issue_controller_if.sv
// Handshake bundle between fetch/decode/datapath and the uop issue controller.
// CNT_W must match the controller's CNT_W.
interface uop_issue_controller_if #(
    parameter int CNT_W = 32
);
    logic             instr_valid;
    logic             instr_ready;
    logic [5:0]       mapped_addr;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             mul_start;
    logic             mul_done;
    logic [5:0]       uop_addr;
    logic             reg_we;
    logic             pc_redirect;
    logic             retire;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output instr_valid, mapped_addr, branch_taken, mem_ack, mul_done,
        input  instr_ready, mem_req, mul_start, uop_addr, reg_we,
               pc_redirect, retire, trap, trap_cause, retire_count
    );

    modport slave (
        input  instr_valid, mapped_addr, branch_taken, mem_ack, mul_done,
        output instr_ready, mem_req, mul_start, uop_addr, reg_we,
               pc_redirect, retire, trap, trap_cause, retire_count
    );
endinterface

// File: rtl/uop_issue_controller.sv
// Multi-cycle issue/sequencing FSM for the microcoded RV32 core: walks one
// instruction at a time through EXEC/MEM/MULW/WB and raises traps.
module uop_issue_controller #(
    parameter int MUL_TIMEOUT = 32,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    uop_issue_controller_if.slave   bus
);
    localparam int TO_W = $clog2(MUL_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_MEM, S_MULW, S_WB, S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_MUL, C_ILL
    } cls_e;

    function automatic cls_e classify(input logic [5:0] a);
        if (a == 6'd0)       return C_NOP;
        else if (a == 6'd11) return C_LOAD;
        else if (a == 6'd12) return C_STORE;
        else if (a == 6'd13) return C_BRANCH;
        else if (a <= 6'd24) return C_ALU;
        else if (a <= 6'd26) return C_JUMP;
        else if (a <= 6'd29) return C_MUL;
        else                 return C_ILL;
    endfunction

    state_e           state_q, state_d;
    logic [5:0]       uop_addr_q;
    logic [1:0]       trap_cause_q;
    logic [CNT_W-1:0] retire_count_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             taken_q, taken_d;
    logic             instr_ready_q, mem_req_q, mul_start_q;
    logic             reg_we_q, pc_redirect_q, retire_q, trap_q;

    cls_e cls_acc, cls_q;
    logic accept, to_expire;

    always_comb begin
        cls_acc   = classify(bus.mapped_addr);
        cls_q     = classify(uop_addr_q);
        accept    = (state_q == S_IDLE) && bus.instr_valid;
        to_expire = (to_cnt_q == TO_W'(MUL_TIMEOUT - 1));
        state_d   = state_q;
        taken_d   = taken_q;
        case (state_q)
            S_IDLE: if (bus.instr_valid) begin
                if (cls_acc == C_ILL)      state_d = S_TRAP;
                else if (cls_acc == C_MUL) state_d = S_MULW;
                else                       state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cls_q == C_BRANCH) taken_d = bus.branch_taken;
                state_d = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
            end
            S_MEM:  if (bus.mem_ack) state_d = S_WB;
            // A result arriving on the last allowed cycle still beats the timeout.
            S_MULW: begin
                if (bus.mul_done)   state_d = S_WB;
                else if (to_expire) state_d = S_TRAP;
            end
            S_WB, S_TRAP: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            uop_addr_q     <= '0;
            trap_cause_q   <= '0;
            retire_count_q <= '0;
            to_cnt_q       <= '0;
            taken_q        <= 1'b0;
            instr_ready_q  <= 1'b1;
            mem_req_q      <= 1'b0;
            mul_start_q    <= 1'b0;
            reg_we_q       <= 1'b0;
            pc_redirect_q  <= 1'b0;
            retire_q       <= 1'b0;
            trap_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            taken_q       <= taken_d;
            instr_ready_q <= (state_d == S_IDLE);
            mem_req_q     <= (state_d == S_MEM);
            mul_start_q   <= (state_q == S_IDLE) && (state_d == S_MULW);
            retire_q      <= (state_d == S_WB);
            trap_q        <= (state_d == S_TRAP);
            reg_we_q      <= (state_d == S_WB) &&
                             (cls_q == C_ALU || cls_q == C_LOAD ||
                              cls_q == C_JUMP || cls_q == C_MUL);
            pc_redirect_q <= (state_d == S_WB) &&
                             (cls_q == C_JUMP || (cls_q == C_BRANCH && taken_d));
            if (accept) begin
                uop_addr_q   <= bus.mapped_addr;
                trap_cause_q <= (cls_acc == C_ILL) ? 2'd1 : 2'd0;
                to_cnt_q     <= '0;
            end
            if (state_q == S_MULW) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
                if (!bus.mul_done && to_expire) trap_cause_q <= 2'd2;
            end
            if (state_q == S_WB) retire_count_q <= retire_count_q + CNT_W'(1);
        end
    end

    assign bus.instr_ready  = instr_ready_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mul_start    = mul_start_q;
    assign bus.uop_addr     = uop_addr_q;
    assign bus.reg_we       = reg_we_q;
    assign bus.pc_redirect  = pc_redirect_q;
    assign bus.retire       = retire_q;
    assign bus.trap         = trap_q;
    assign bus.trap_cause   = trap_cause_q;
    assign bus.retire_count = retire_count_q;
endmodule
